// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two requesters, the UART transmitter and uart_tx_sched.
// master: requesters plus transmitter side; slave: the scheduler.
interface uart_tx_sched_if;
    logic        A_REQ;
    logic [15:0] A_DATA;
    logic        A_ACK;
    logic        B_REQ;
    logic [7:0]  B_DATA;
    logic        B_ACK;
    logic        TX_BUSY;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        SCHED_BUSY;
    logic        TO_ERR;

    modport master (
        output A_REQ, A_DATA, B_REQ, B_DATA, TX_BUSY,
        input  A_ACK, B_ACK, TX_P_DATA, TX_D_VLD, SCHED_BUSY, TO_ERR
    );

    modport slave (
        input  A_REQ, A_DATA, B_REQ, B_DATA, TX_BUSY,
        output A_ACK, B_ACK, TX_P_DATA, TX_D_VLD, SCHED_BUSY, TO_ERR
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding a word source (A, 2 bytes LSB first) and a byte source (B) to one UART.
// Define UART_TX_SCHED_TIMEOUT_EN to abort a message when TX_BUSY never rises within TO_CYCLES.
module uart_tx_sched #(
    parameter int TO_CYCLES = 16
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_sched_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, NEXT} state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q;
    logic        word_q;
    logic        idx_q;
    logic        pri_a_q;
    logic        grant_a, grant_b;
    logic        more_bytes;
    logic [7:0]  cur_byte;
    logic        to_fire;
    logic        to_err_q;

    logic        a_ack, b_ack, tx_d_vld, sched_busy, to_err;
    logic [7:0]  tx_p_data;

    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_to_range
        $error("uart_tx_sched: TO_CYCLES must be within 2..255");
    end

    assign more_bytes = word_q && !idx_q;
    assign cur_byte   = idx_q ? data_q[15:8] : data_q[7:0];

    // pri_a_q set means A wins a tie; it flips to the other side on every grant
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE && !RST && !bus.TX_BUSY) begin
            if (bus.A_REQ && (pri_a_q || !bus.B_REQ)) begin
                grant_a = 1'b1;
            end else if (bus.B_REQ) begin
                grant_b = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_a || grant_b) state_d = ISSUE;
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (bus.TX_BUSY) begin
                    state_d = WAIT_LO;
                end else if (to_fire) begin
                    state_d = IDLE;
                end
            end
            WAIT_LO: if (!bus.TX_BUSY) state_d = NEXT;
            NEXT:    state_d = more_bytes ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= '0;
            word_q  <= 1'b0;
            idx_q   <= 1'b0;
            pri_a_q <= 1'b1;
        end else if (grant_a) begin
            data_q  <= bus.A_DATA;
            word_q  <= 1'b1;
            idx_q   <= 1'b0;
            pri_a_q <= 1'b0;
        end else if (grant_b) begin
            data_q  <= {8'h00, bus.B_DATA};
            word_q  <= 1'b0;
            idx_q   <= 1'b0;
            pri_a_q <= 1'b1;
        end else if (state_q == NEXT && more_bytes) begin
            idx_q   <= 1'b1;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] to_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= to_fire;
            if (state_q == WAIT_HI) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign to_fire = (state_q == WAIT_HI) && !bus.TX_BUSY && (to_cnt_q == TO_LAST);
`else
    assign to_fire  = 1'b0;
    assign to_err_q = 1'b0;
`endif

    // Outputs are forced low while RST is high so reset wins in its own cycle
    always_comb begin
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        tx_d_vld   = 1'b0;
        tx_p_data  = '0;
        sched_busy = 1'b0;
        to_err     = 1'b0;
        if (!RST) begin
            a_ack    = grant_a;
            b_ack    = grant_b;
            tx_d_vld = (state_q == ISSUE);
            to_err   = to_err_q;
            if (state_q inside {ISSUE, WAIT_HI, WAIT_LO}) begin
                tx_p_data = cur_byte;
            end
            unique case (state_q)
                IDLE:    sched_busy = grant_a || grant_b;
                NEXT:    sched_busy = more_bytes;
                default: sched_busy = 1'b1;
            endcase
        end
    end

    assign bus.A_ACK      = a_ack;
    assign bus.B_ACK      = b_ack;
    assign bus.TX_D_VLD   = tx_d_vld;
    assign bus.TX_P_DATA  = tx_p_data;
    assign bus.SCHED_BUSY = sched_busy;
    assign bus.TO_ERR     = to_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: requester queues and a UART model drive the DUT while a
// timestamp-based reference model predicts grants, issued bytes, busy and timeout every cycle.
module tb_uart_tx_sched;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_sched_if bus_if ();

    uart_tx_sched #(.TO_CYCLES(TO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // stimulus state
    logic [15:0] a_pend[$];
    logic [7:0]  b_pend[$];
    bit          rst_now  = 1'b1;
    bit          hold_low = 1'b0;
    bit          sp_en    = 1'b0;
    int          fix_d    = 1;
    int          fix_len  = 10;
    int          busy_start = -1, busy_end = -1;
    int          sp_start   = -1, sp_end   = -1;

    // reference model
    logic [7:0]  exp_bytes[$];
    int          msg_left = 0;
    int          next_iss = -1;
    int          free_cyc = 0;
    int          to_cyc   = -1;
    bit          a_prio   = 1'b1;
    bit          byte_active = 1'b0;
    logic [7:0]  cur_byte = '0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit exp_a, exp_b, exp_vld;
        int d, len;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_now;
        bus_if.A_REQ = (a_pend.size() > 0);
        if (a_pend.size() > 0) bus_if.A_DATA = a_pend[0];
        bus_if.B_REQ = (b_pend.size() > 0);
        if (b_pend.size() > 0) bus_if.B_DATA = b_pend[0];
        bus_if.TX_BUSY = (cyc >= busy_start && cyc < busy_end) || (cyc >= sp_start && cyc < sp_end);
        @(negedge clk);

        if (rst_now) begin
            check("rst_outs", {bus_if.A_ACK, bus_if.B_ACK, bus_if.TX_D_VLD, bus_if.SCHED_BUSY,
                               bus_if.TO_ERR, bus_if.TX_P_DATA}, 16'h0000);
            exp_bytes.delete();
            msg_left    = 0;
            next_iss    = -1;
            a_prio      = 1'b1;
            free_cyc    = cyc + 1;
            to_cyc      = -1;
            byte_active = 1'b0;
            return;
        end

`ifdef UART_TX_SCHED_TIMEOUT_EN
        check("to_err", bus_if.TO_ERR, 16'(cyc == to_cyc));
        if (cyc == to_cyc) begin
            exp_bytes.delete();
            msg_left    = 0;
            byte_active = 1'b0;
            free_cyc    = cyc;
            to_cyc      = -1;
        end
`else
        check("to_err", bus_if.TO_ERR, 16'h0000);
`endif

        // grant: only between messages, transmitter idle, round-robin on ties
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (msg_left == 0 && cyc >= free_cyc && !bus_if.TX_BUSY) begin
            if (bus_if.A_REQ && (a_prio || !bus_if.B_REQ)) exp_a = 1'b1;
            else if (bus_if.B_REQ) exp_b = 1'b1;
        end
        check("a_ack", bus_if.A_ACK, 16'(exp_a));
        check("b_ack", bus_if.B_ACK, 16'(exp_b));
        check("ack_excl", 16'(bus_if.A_ACK & bus_if.B_ACK), 16'h0000);
        if (exp_a) begin
            exp_bytes.push_back(a_pend[0][7:0]);
            exp_bytes.push_back(a_pend[0][15:8]);
            void'(a_pend.pop_front());
            msg_left = 2;
            next_iss = cyc + 1;
            a_prio   = 1'b0;
        end
        if (exp_b) begin
            exp_bytes.push_back(b_pend.pop_front());
            msg_left = 1;
            next_iss = cyc + 1;
            a_prio   = 1'b1;
        end

        check("sched_busy", bus_if.SCHED_BUSY, 16'(msg_left > 0));

        exp_vld = (cyc == next_iss);
        check("tx_d_vld", bus_if.TX_D_VLD, 16'(exp_vld));
        check("vld_vs_busy", 16'(bus_if.TX_D_VLD & bus_if.TX_BUSY), 16'h0000);
        if (exp_vld) begin
            cur_byte    = exp_bytes[0];
            byte_active = 1'b1;
            next_iss    = -1;
            if (hold_low) begin
                busy_start = -1;
                busy_end   = -1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                to_cyc = cyc + 1 + TO;
`endif
            end else begin
                d   = (fix_d   != 0) ? fix_d   : int'($urandom_range(1, 3));
                len = (fix_len != 0) ? fix_len : int'($urandom_range(1, 10));
                busy_start = cyc + d;
                busy_end   = busy_start + len;
            end
        end
        if (byte_active) check("tx_p_data", 16'(bus_if.TX_P_DATA), 16'(cur_byte));

        // busy fall completes the byte; next byte or next grant two cycles later
        if (byte_active && cyc == busy_end) begin
            byte_active = 1'b0;
            void'(exp_bytes.pop_front());
            msg_left--;
            if (msg_left > 0) next_iss = cyc + 2;
            else free_cyc = cyc + 2;
        end

        if (sp_en && msg_left == 0 && cyc >= busy_end && cyc >= sp_end && $urandom_range(0, 9) == 0) begin
            sp_start = cyc + 1;
            sp_end   = sp_start + int'($urandom_range(1, 3));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_bytes"}, 16'(exp_bytes.size() + msg_left), 16'h0000);
        check({tag, "_pend"}, 16'(a_pend.size() + b_pend.size()), 16'h0000);
    endtask

    initial begin
        bit found;
        bus_if.A_REQ   = 1'b0;
        bus_if.A_DATA  = '0;
        bus_if.B_REQ   = 1'b0;
        bus_if.B_DATA  = '0;
        bus_if.TX_BUSY = 1'b0;

        rst_now = 1'b1;
        run(3);
        rst_now = 1'b0;
        run(2);

        // single byte from B, busy one cycle after valid for ten cycles
        b_pend.push_back(8'hA5);
        run(20);
        check_drained("b_byte");

        // simultaneous, both held: A B A B
        a_pend.push_back(16'h1111);
        a_pend.push_back(16'h2222);
        b_pend.push_back(8'h33);
        b_pend.push_back(8'h44);
        run(120);
        check_drained("rr");

        // word from A, LSB first
        a_pend.push_back(16'h1234);
        run(40);
        check_drained("a_word");

        // reset while waiting for the first byte of A to finish
        a_pend.push_back(16'h1234);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus_if.TX_BUSY) found = 1'b1;
        end
        check("wait_busy", 16'(found), 16'h0001);
        step();
        rst_now = 1'b1;
        step();
        rst_now = 1'b0;
        step();
        check("post_rst", {bus_if.A_ACK, bus_if.B_ACK, bus_if.TX_D_VLD, bus_if.SCHED_BUSY,
                           bus_if.TO_ERR, bus_if.TX_P_DATA}, 16'h0000);
        a_pend.push_back(16'h5678);
        b_pend.push_back(8'h9A);
        run(80);
        check_drained("after_rst");

        // B request arriving mid-message waits for the word to finish
        a_pend.push_back(16'hCAFE);
        run(4);
        b_pend.push_back(8'h77);
        run(60);
        check_drained("b_wait");

        // transmitter never answers
        hold_low = 1'b1;
        a_pend.push_back(16'hBEEF);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        run(30);
        hold_low = 1'b0;
        check_drained("timeout");
        b_pend.push_back(8'h3C);
        run(20);
        check_drained("post_to");
`else
        run(40);
        hold_low   = 1'b0;
        busy_start = cyc + 1;
        busy_end   = cyc + 4;
        run(30);
        check_drained("no_timeout");
`endif

        // random traffic with random transmitter timing and stray busy while idle
        fix_d   = 0;
        fix_len = 0;
        sp_en   = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0 && a_pend.size() < 3) a_pend.push_back(16'($urandom));
            if ($urandom_range(0, 5) == 0 && b_pend.size() < 3) b_pend.push_back(8'($urandom));
            step();
        end
        sp_en = 1'b0;
        run(400);
        check_drained("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
